// File: rtl/datapath_pkg.sv
// Shared constants and types for the single-bus CPU datapath:
// bus/register index map, ALU operation codes, branch-condition codes
// and the CON flip-flop condition evaluator.
package datapath_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 32;

  // Bus source / load-enable index map (0..15 are the GPRs R0..R15).
  localparam logic [4:0] IDX_HI  = 5'd16;
  localparam logic [4:0] IDX_LO  = 5'd17;
  localparam logic [4:0] IDX_ZHI = 5'd18;  // drive only
  localparam logic [4:0] IDX_ZLO = 5'd19;  // drives Z[31:0], loads all of Z
  localparam logic [4:0] IDX_PC  = 5'd20;
  localparam logic [4:0] IDX_IR  = 5'd21;
  localparam logic [4:0] IDX_MDR = 5'd22;
  localparam logic [4:0] IDX_MAR = 5'd23;
  localparam logic [4:0] IDX_Y   = 5'd24;
  localparam logic [4:0] IDX_C   = 5'd25;  // sign-extended IR[18:0], drive only

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_AND  = 6'd2,
    ALU_OR   = 6'd3,
    ALU_SHR  = 6'd4,
    ALU_SHRA = 6'd5,
    ALU_SHL  = 6'd6,
    ALU_ROR  = 6'd7,
    ALU_ROL  = 6'd8,
    ALU_MUL  = 6'd9,
    ALU_DIV  = 6'd10,
    ALU_NEG  = 6'd11,
    ALU_NOT  = 6'd12
  } alu_op_e;

  // Branch condition carried in IR[20:19].
  typedef enum logic [1:0] {
    CON_EQ = 2'b00,
    CON_NE = 2'b01,
    CON_GE = 2'b10,
    CON_LT = 2'b11
  } con_cond_e;

  function automatic logic con_eval(input logic [1:0] cond, input logic [DATA_W-1:0] v);
    case (con_cond_e'(cond))
      CON_EQ:  return (v == '0);
      CON_NE:  return (v != '0);
      CON_GE:  return ~v[DATA_W-1];
      default: return v[DATA_W-1];
    endcase
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus. Produces a 64-bit
// result for Z; 32-bit operations are zero-extended into the upper half.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [5:0]          op_i,
  output logic [2*DATA_W-1:0] result_o
);

  logic [4:0]                 shamt;
  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   b_s;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic [DATA_W-1:0]          r32;
  logic [2*DATA_W-1:0]        dbl;
  logic                       wide;

  assign shamt = b_i[4:0];
  assign a_s   = a_i;
  assign b_s   = b_i;
  assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};

  // Operation select; rotates go through a doubled copy of A.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    r32      = '0;
    dbl      = '0;
    wide     = 1'b0;
    result_o = '0;
    case (op_i)
      ALU_ADD:  r32 = a_i + b_i;
      ALU_SUB:  r32 = a_i - b_i;
      ALU_AND:  r32 = a_i & b_i;
      ALU_OR:   r32 = a_i | b_i;
      ALU_SHR:  r32 = a_i >> shamt;
      ALU_SHRA: r32 = a_s >>> shamt;
      ALU_SHL:  r32 = a_i << shamt;
      ALU_ROR: begin
        dbl = {a_i, a_i} >> shamt;
        r32 = dbl[DATA_W-1:0];
      end
      ALU_ROL: begin
        dbl = {a_i, a_i} << shamt;
        r32 = dbl[2*DATA_W-1:DATA_W];
      end
      ALU_MUL: begin
        wide     = 1'b1;
        result_o = a_ext * b_ext;
      end
      ALU_DIV: begin
        wide = 1'b1;
        // Divide by zero yields Z = 0 rather than an undefined quotient.
        if (b_i != '0) result_o = {a_s % b_s, a_s / b_s};
      end
      ALU_NEG:  r32 = '0 - b_i;
      ALU_NOT:  r32 = ~b_i;
      default:  r32 = b_i;
    endcase
    if (!wide) result_o = {{DATA_W{1'b0}}, r32};
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, HI, LO, PC, IR, MAR, MDR, Y,
// 64-bit Z, ALU and CON flip-flop around one shared bus.
// Optional feature macro: DATAPATH_INTERNAL_RAM_EN adds an internal RAM
// addressed by MAR that feeds MDR and is written from MDR.
module datapath
#(
  parameter int DATA_W    = datapath_pkg::DATA_W,
  parameter int NUM_GPR   = 16,
  parameter int RAM_DEPTH = 512
)(
  input  logic              clock,
  input  logic              clr,
  output logic [DATA_W-1:0] bus_contents,
  input  logic [31:0]       enc_input,
  input  logic [31:0]       reg_enable,
  input  logic [5:0]        ALU_Sel,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              read,
  input  logic              write,
  input  logic              incPC,
  input  logic [3:0]        Gra,
  input  logic [3:0]        Grb,
  input  logic [3:0]        Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              conIn,
  output logic              CONFFOut
);

  import datapath_pkg::*;

  logic [DATA_W-1:0]   gpr_q [NUM_GPR];
  logic [DATA_W-1:0]   hi_q, lo_q, pc_q, ir_q, mdr_q, mar_q, y_q;
  logic [2*DATA_W-1:0] z_q, z_d, alu_res;
  logic                con_q, con_d;
  logic [DATA_W-1:0]   mdr_d, mem_rdata, c_sext, bus;
  logic [4:0]          src_idx;
  logic                src_hit;

  assign c_sext = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};

  // Priority encoder: the lowest set bit of enc_input owns the bus.
  always_comb begin
    // NOTE: blocking assignments in combinational logic; the downward loop leaves the lowest hit last.
    src_hit = 1'b0;
    src_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (enc_input[i]) begin
        src_hit = 1'b1;
        src_idx = 5'(i);
      end
    end
  end

  // Bus multiplexer; encoded sources beat Rout, which beats BAout.
  always_comb begin
    bus = '0;
    if (src_hit) begin
      case (src_idx)
        IDX_HI:  bus = hi_q;
        IDX_LO:  bus = lo_q;
        IDX_ZHI: bus = z_q[2*DATA_W-1:DATA_W];
        IDX_ZLO: bus = z_q[DATA_W-1:0];
        IDX_PC:  bus = pc_q;
        IDX_IR:  bus = ir_q;
        IDX_MDR: bus = mdr_q;
        IDX_MAR: bus = mar_q;
        IDX_Y:   bus = y_q;
        IDX_C:   bus = c_sext;
        default: if (!src_idx[4]) bus = gpr_q[src_idx[3:0]];
      endcase
    end else if (Rout) begin
      bus = gpr_q[Grb];
    end else if (BAout) begin
      // Base-address read: R0 reads as zero so it can act as "no base".
      bus = (Grc == '0) ? '0 : gpr_q[Grc];
    end
  end

  assign bus_contents = bus;

  datapath_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus),
    .op_i     (ALU_Sel),
    .result_o (alu_res)
  );

  // Next-state values for Z, MDR and CON.
  always_comb begin
    z_d   = incPC ? {{DATA_W{1'b0}}, bus + 1'b1} : alu_res;
    mdr_d = read ? mem_rdata : bus;
    con_d = con_eval(ir_q[20:19], bus);
  end

`ifdef DATAPATH_INTERNAL_RAM_EN
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  // Internal RAM: asynchronous read at MAR, MDR written on the edge.
  always_ff @(posedge clock) begin
    // NOTE: the RAM array has no reset; clr leaves its contents intact.
    if (write) ram_q[mar_q[RAM_AW-1:0]] <= mdr_q;
  end

  assign mem_rdata = ram_q[mar_q[RAM_AW-1:0]];

  logic unused_ok;
  assign unused_ok = ^{Mdatain, reg_enable[31:25], reg_enable[IDX_ZHI]};
`else
  localparam int unused_ram_depth = RAM_DEPTH;

  assign mem_rdata = Mdatain;

  logic unused_ok;
  assign unused_ok = ^{write, reg_enable[31:25], reg_enable[IDX_ZHI]};
`endif

  // Register file and special registers load from the bus; clr wins.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all state; clr is sampled on the edge (synchronous).
    if (clr) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
      mar_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      con_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (reg_enable[i] || (Rin && (Gra == 4'(i)))) gpr_q[i] <= bus;
      end
      if (reg_enable[IDX_HI])           hi_q  <= bus;
      if (reg_enable[IDX_LO])           lo_q  <= bus;
      if (reg_enable[IDX_PC])           pc_q  <= bus;
      if (reg_enable[IDX_IR])           ir_q  <= bus;
      if (reg_enable[IDX_MDR])          mdr_q <= mdr_d;
      if (reg_enable[IDX_MAR])          mar_q <= bus;
      if (reg_enable[IDX_Y])            y_q   <= bus;
      if (reg_enable[IDX_ZLO] || incPC) z_q   <= z_d;
      if (conIn)                        con_q <= con_d;
    end
  end

  assign CONFFOut = con_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for the single-bus datapath. Each cycle the bench
// computes the expected bus value and CON state from its own register-level
// model of the machine, queues them, and an independent negedge monitor
// compares them with the DUT outputs.
module tb_datapath;

  logic        clock;
  logic        clr;
  logic [31:0] bus_contents;
  logic [31:0] enc_input;
  logic [31:0] reg_enable;
  logic [5:0]  ALU_Sel;
  logic [31:0] Mdatain;
  logic        read, write, incPC;
  logic [3:0]  Gra, Grb, Grc;
  logic        Rin, Rout, BAout, conIn;
  logic        CONFFOut;

  datapath dut (
    .clock        (clock),
    .clr          (clr),
    .bus_contents (bus_contents),
    .enc_input    (enc_input),
    .reg_enable   (reg_enable),
    .ALU_Sel      (ALU_Sel),
    .Mdatain      (Mdatain),
    .read         (read),
    .write        (write),
    .incPC        (incPC),
    .Gra          (Gra),
    .Grb          (Grb),
    .Grc          (Grc),
    .Rin          (Rin),
    .Rout         (Rout),
    .BAout        (BAout),
    .conIn        (conIn),
    .CONFFOut     (CONFFOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model state ----------------
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mdr, m_mar, m_y;
  logic [63:0] m_z;
  logic        m_con;

  typedef struct {
    string       tag;
    logic [31:0] bus;
    logic        con;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model of the bus: first requested source in index order, then Rout, then BAout.
  function automatic logic [31:0] ref_bus();
    int first = -1;
    for (int i = 0; i < 32; i++) if (enc_input[i] && first < 0) first = i;
    if (first >= 0) begin
      if (first < 16) return m_r[first];
      case (first)
        16: return m_hi;
        17: return m_lo;
        18: return m_z[63:32];
        19: return m_z[31:0];
        20: return m_pc;
        21: return m_ir;
        22: return m_mdr;
        23: return m_mar;
        24: return m_y;
        25: return m_ir[18] ? {13'h1fff, m_ir[18:0]} : {13'h0, m_ir[18:0]};
        default: return 32'h0;
      endcase
    end
    if (Rout) return m_r[Grb];
    if (BAout) return (Grc == 0) ? 32'h0 : m_r[Grc];
    return 32'h0;
  endfunction

  // Model of the ALU using integer arithmetic and bit-by-bit rotation.
  function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb_v, sh;
    logic [31:0] x;
    longint      p;
    sa = a;
    sb_v = b;
    sh = b[4:0];
    x = a;
    case (op)
      0:  x = a + b;
      1:  x = a - b;
      2:  x = a & b;
      3:  x = a | b;
      4:  x = a >> sh;
      5:  x = sa >>> sh;
      6:  x = a << sh;
      7:  repeat (sh) x = {x[0], x[31:1]};
      8:  repeat (sh) x = {x[30:0], x[31]};
      9: begin
        p = longint'(sa) * longint'(sb_v);
        return p;
      end
      10: begin
        if (sb_v == 0) return 64'h0;
        return {32'(sa % sb_v), 32'(sa / sb_v)};
      end
      11: x = 32'h0 - b;
      12: x = ~b;
      default: x = b;
    endcase
    return {32'h0, x};
  endfunction

  // Advance the model by one clock edge with the current control inputs.
  task automatic ref_update(input logic [31:0] b);
    logic [63:0] z_n;
    logic        con_n;
    logic [31:0] mdr_n;
    if (clr) begin
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      {m_hi, m_lo, m_pc, m_ir, m_mdr, m_mar, m_y} = '0;
      m_z = 0;
      m_con = 0;
      return;
    end
    z_n = incPC ? {32'h0, b + 32'd1} : ref_alu(int'(ALU_Sel), m_y, b);
    case (m_ir[20:19])
      2'b00: con_n = (b == 0);
      2'b01: con_n = (b != 0);
      2'b10: con_n = (int'(b) >= 0);
      default: con_n = (int'(b) < 0);
    endcase
    mdr_n = read ? Mdatain : b;
    for (int i = 0; i < 16; i++) if (reg_enable[i] || (Rin && Gra == i)) m_r[i] = b;
    if (reg_enable[16]) m_hi = b;
    if (reg_enable[17]) m_lo = b;
    if (reg_enable[20]) m_pc = b;
    if (reg_enable[21]) m_ir = b;
    if (reg_enable[22]) m_mdr = mdr_n;
    if (reg_enable[23]) m_mar = b;
    if (reg_enable[24]) m_y = b;
    if (reg_enable[19] || incPC) m_z = z_n;
    if (conIn) m_con = con_n;
  endtask

  task automatic set_idle();
    enc_input = '0; reg_enable = '0; ALU_Sel = '0; Mdatain = '0;
    read = 0; write = 0; incPC = 0; Gra = 0; Grb = 0; Grc = 0;
    Rin = 0; Rout = 0; BAout = 0; conIn = 0; clr = 0;
  endtask

  // One clock cycle: queue expectations, let the monitor compare, step the model.
  task automatic tick(input string tag, input bit chk,
                      input bit ub = 0, input logic [31:0] bc = 0,
                      input bit uc = 0, input logic cc = 0);
    exp_t        e;
    logic [31:0] b;
    b = ref_bus();
    if (chk) begin
      e.tag = tag;
      e.bus = ub ? bc : b;
      e.con = uc ? cc : m_con;
      sb.push_back(e);
    end
    mon_en = chk;
    @(negedge clock);
    ref_update(b);
    @(posedge clock);
    #1;
    mon_en = 0;
    set_idle();
  endtask

  task automatic peek(input string tag, input int src, input logic [31:0] v);
    set_idle();
    enc_input[src] = 1'b1;
    tick(tag, 1, 1, v);
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    set_idle();
    read = 1; Mdatain = v; reg_enable[22] = 1'b1;
    tick("ld_mdr", 1);
    enc_input[22] = 1'b1; reg_enable[idx] = 1'b1;
    tick("set_reg", 1);
  endtask

  // Monitor: independent of stimulus, compares whatever is queued.
  always @(negedge clock) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: no expectation queued at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus_contents !== e.bus) begin
          errors++;
          $display("FAIL %s bus: got %h expected %h", e.tag, bus_contents, e.bus);
        end
        checks++;
        if (CONFFOut !== e.con) begin
          errors++;
          $display("FAIL %s con: got %b expected %b", e.tag, CONFFOut, e.con);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    {m_hi, m_lo, m_pc, m_ir, m_mdr, m_mar, m_y} = '0;
    m_z = 0; m_con = 0;
    set_idle();

    // clr with every enable asserted: clr must dominate.
    clr = 1; reg_enable = '1; conIn = 1; incPC = 1; Rin = 1;
    tick("clr", 0);
    tick("clr_bus", 1, 1, 32'h0, 1, 1'b0);
    for (int i = 0; i < 26; i++) peek($sformatf("clr_src%0d", i), i, 32'h0);

    // PC increment through Z while MAR captures the old PC.
    set_reg(20, 32'd5);
    set_idle(); enc_input[20] = 1; reg_enable[23] = 1; incPC = 1;
    tick("pc_drive", 1, 1, 32'd5);
    peek("mar_pc", 23, 32'd5);
    set_idle(); enc_input[19] = 1; reg_enable[20] = 1;
    tick("zlo_inc", 1, 1, 32'd6);
    peek("pc_inc", 20, 32'd6);

    // Memory read into MDR, then into IR.
    set_idle(); read = 1; Mdatain = 32'h1234_5678; reg_enable[22] = 1;
    tick("mdr_rd", 1);
    peek("mdr_val", 22, 32'h1234_5678);
    set_idle(); enc_input[22] = 1; reg_enable[21] = 1;
    tick("ir_ld", 1);
    peek("ir_val", 21, 32'h1234_5678);
    peek("c_sext", 25, 32'hFFFC_5678);

    // mfhi / mflo via Rin.
    set_reg(16, 32'h0000_DEAD);
    set_idle(); enc_input[16] = 1; Rin = 1; Gra = 2;
    tick("mfhi", 1);
    peek("mfhi_r2", 2, 32'h0000_DEAD);
    set_reg(17, 32'h0000_BEEF);
    set_idle(); enc_input[17] = 1; Rin = 1; Gra = 2;
    tick("mflo", 1);
    peek("mflo_r2", 2, 32'h0000_BEEF);

    // mul / div, including negative dividend and divide by zero.
    set_reg(24, 32'd7); set_reg(3, 32'd3);
    set_idle(); enc_input[3] = 1; ALU_Sel = 9; reg_enable[19] = 1;
    tick("mul", 1);
    peek("mul_lo", 19, 32'd21); peek("mul_hi", 18, 32'd0);
    set_idle(); enc_input[3] = 1; ALU_Sel = 10; reg_enable[19] = 1;
    tick("div", 1);
    peek("div_q", 19, 32'd2); peek("div_r", 18, 32'd1);
    set_reg(24, 32'hFFFF_FFF9); set_reg(3, 32'd2);
    set_idle(); enc_input[3] = 1; ALU_Sel = 10; reg_enable[19] = 1;
    tick("div_neg", 1);
    peek("divn_q", 19, 32'hFFFF_FFFD); peek("divn_r", 18, 32'hFFFF_FFFF);
    set_reg(3, 32'd0);
    set_idle(); enc_input[3] = 1; ALU_Sel = 10; reg_enable[19] = 1;
    tick("div_zero", 1);
    peek("div0_q", 19, 32'd0); peek("div0_r", 18, 32'd0);

    // CON with IR[20:19]=00 (equal to zero).
    set_reg(21, 32'h0); set_reg(0, 32'h0);
    set_idle(); enc_input[0] = 1; conIn = 1;
    tick("con_eq_ld", 1);
    tick("con_eq", 1, 1, 32'h0, 1, 1'b1);
    set_reg(1, 32'd1);
    set_idle(); enc_input[1] = 1; conIn = 1;
    tick("con_ne_ld", 1);
    tick("con_ne", 1, 1, 32'h0, 1, 1'b0);

    // BAout reads R0 as zero; Rout does not.
    set_reg(0, 32'h55);
    set_idle(); BAout = 1; Grc = 0;
    tick("baout_r0", 1, 1, 32'h0);
    set_idle(); BAout = 1; Grc = 1;
    tick("baout_r1", 1, 1, 32'd1);
    set_idle(); Rout = 1; Grb = 0;
    tick("rout_r0", 1, 1, 32'h55);

    // Priority: lowest set bit wins; an unused lowest bit gives 0 over Rout.
    set_idle(); enc_input[20] = 1; enc_input[1] = 1;
    tick("prio_low", 1, 1, 32'd1);
    set_idle(); enc_input[26] = 1; Rout = 1;
    tick("unused_src", 1, 1, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      set_idle();
      kind = $urandom_range(0, 7);
      case (kind)
        0: begin
          read = 1; Mdatain = $urandom; reg_enable[22] = 1;
          tick("rand_mdr", 1);
        end
        1, 2: begin
          enc_input = 32'h1 << $urandom_range(0, 31);
          reg_enable = 32'h1 << $urandom_range(0, 25);
          tick("rand_move", 1);
        end
        3: begin
          enc_input = 32'h1 << $urandom_range(0, 25);
          ALU_Sel = 6'($urandom_range(0, 20));
          reg_enable[19] = 1;
          b = ref_bus();
          if (ALU_Sel == 10 && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF) ALU_Sel = 0;
          tick("rand_alu", 1);
        end
        4: begin
          enc_input = 32'h1 << $urandom_range(18, 19);
          tick("rand_z", 1);
        end
        5: begin
          enc_input = 32'h1 << $urandom_range(0, 25);
          conIn = 1;
          tick("rand_con", 1);
        end
        6: begin
          Rout = 1'($urandom); BAout = 1'($urandom);
          Grb = 4'($urandom); Grc = 4'($urandom);
          Rin = 1'($urandom); Gra = 4'($urandom);
          tick("rand_gr", 1);
        end
        default: begin
          enc_input = $urandom & $urandom;
          reg_enable = $urandom & $urandom & $urandom;
          read = 1'($urandom); Mdatain = $urandom; write = 1'($urandom);
          incPC = ($urandom_range(0, 3) == 0);
          conIn = 1'($urandom);
          clr = ($urandom_range(0, 15) == 0);
          ALU_Sel = 6'($urandom_range(0, 8));
          tick("rand_mix", 1);
        end
      endcase
    end

    tick("drain", 0);
    tick("drain", 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
